// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and the
// fetch FSM state type. Imported by the fetch stage and the control unit.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] OP_JUMP  = 4'b1100;

  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 12;
  localparam int unsigned FUNC_HI = 3;
  localparam int unsigned FUNC_LO = 0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT,
    ST_TRAP
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction word, its PC and a valid flag.
// flush clears valid (data is kept), hold freezes everything, load captures.
module ifid_reg #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               hold,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  // Priority flush > hold > load; a flush must win even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold && load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory, feeds the
// IF/ID register, and sequences branch redirect, halt drain and opcode trap.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int unsigned          DRAIN_CYC = 3
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [ADDR_W-1:0]  IMEM_ADDR,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  input  logic               STALL,
  input  logic               BRANCH_TAKEN,
  input  logic [ADDR_W-1:0]  BRANCH_TARGET,
  input  logic               WRONG_OP_CODE,
  output logic [INSTR_W-1:0] IFID_INSTR,
  output logic [ADDR_W-1:0]  IFID_PC,
  output logic               IFID_VALID,
  output logic [3:0]         OP_CODE,
  output logic [3:0]         FUNC_CODE,
  output logic               HALTED,
  output logic               TRAP,
  output logic [15:0]        FETCH_COUNT
);

  localparam int unsigned     CNT_W      = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  drain_cnt;
  logic [15:0]       fetch_count;
  logic              halted;
  logic              trapped;

  logic active;
  logic branch_ev;
  logic trap_ev;
  logic fetch_en;
  logic drain_en;
  logic halt_word;

  // Event decode in edge priority order: branch, trap, stall, then fetch/drain.
  always_comb begin
    active    = (state == ST_RUN) || (state == ST_DRAIN);
    branch_ev = active && BRANCH_TAKEN;
    trap_ev   = active && !BRANCH_TAKEN && WRONG_OP_CODE && IFID_VALID;
    fetch_en  = (state == ST_RUN) && !BRANCH_TAKEN && !trap_ev && !STALL;
    drain_en  = (state == ST_DRAIN) && !BRANCH_TAKEN && !trap_ev && !STALL;
    halt_word = IMEM_DATA[OP_HI:OP_LO] == OP_HALT;
  end

  // FSM with PC, drain counter, fetch counter and sticky status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      drain_cnt   <= '0;
      fetch_count <= '0;
      halted      <= 1'b0;
      trapped     <= 1'b0;
    end else begin
      case (state)
        ST_RUN, ST_DRAIN: begin
          if (branch_ev) begin
            pc        <= BRANCH_TARGET;
            state     <= ST_RUN;
            drain_cnt <= '0;
          end else if (trap_ev) begin
            state   <= ST_TRAP;
            trapped <= 1'b1;
          end else if (fetch_en) begin
            fetch_count <= fetch_count + 16'd1;
            if (halt_word) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              pc <= pc + 1'b1;
            end
          end else if (drain_en) begin
            if (drain_cnt == DRAIN_LAST) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk      (CLK),
    .rst      (RST),
    .load     (fetch_en),
    .flush    (branch_ev || trap_ev || drain_en),
    .hold     (STALL || !active),
    .instr_in (IMEM_DATA),
    .pc_in    (pc),
    .instr    (IFID_INSTR),
    .pc       (IFID_PC),
    .valid    (IFID_VALID)
  );

  assign IMEM_ADDR   = pc;
  assign OP_CODE     = IFID_INSTR[OP_HI:OP_LO];
  assign FUNC_CODE   = IFID_INSTR[FUNC_HI:FUNC_LO];
  assign HALTED      = halted;
  assign TRAP        = trapped;
  assign FETCH_COUNT = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus, a behavioural
// model compared every cycle, plus literal expectations at key points.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IMEM_ADDR;
  logic [15:0] IMEM_DATA;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [15:0] BRANCH_TARGET;
  logic        WRONG_OP_CODE;
  logic [15:0] IFID_INSTR;
  logic [15:0] IFID_PC;
  logic        IFID_VALID;
  logic [3:0]  OP_CODE;
  logic [3:0]  FUNC_CODE;
  logic        HALTED;
  logic        TRAP;
  logic [15:0] FETCH_COUNT;

  logic [15:0] mem [0:65535];
  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  assign IMEM_DATA = mem[IMEM_ADDR];

  fetch_stage #(
    .ADDR_W    (16),
    .INSTR_W   (16),
    .RESET_PC  (16'h0000),
    .DRAIN_CYC (3)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_DATA     (IMEM_DATA),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .WRONG_OP_CODE (WRONG_OP_CODE),
    .IFID_INSTR    (IFID_INSTR),
    .IFID_PC       (IFID_PC),
    .IFID_VALID    (IFID_VALID),
    .OP_CODE       (OP_CODE),
    .FUNC_CODE     (FUNC_CODE),
    .HALTED        (HALTED),
    .TRAP          (TRAP),
    .FETCH_COUNT   (FETCH_COUNT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: mode 0 running, 1 draining, 2 halted, 3 trapped.
  int          m_mode;
  int          m_left;
  logic [15:0] m_pc, m_instr, m_ifpc, m_count;
  logic        m_valid, m_halted, m_trap;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mode = 0; m_left = 0; m_pc = 16'h0000; m_instr = '0; m_ifpc = '0;
      m_count = '0; m_valid = 1'b0; m_halted = 1'b0; m_trap = 1'b0;
    end else if (m_mode < 2) begin
      if (BRANCH_TAKEN) begin
        m_pc = BRANCH_TARGET; m_valid = 1'b0; m_mode = 0;
      end else if (WRONG_OP_CODE && m_valid) begin
        m_mode = 3; m_trap = 1'b1; m_valid = 1'b0;
      end else if (!STALL) begin
        if (m_mode == 0) begin
          m_instr = mem[m_pc]; m_ifpc = m_pc; m_valid = 1'b1; m_count = m_count + 16'd1;
          if (m_instr[15:12] == 4'hF) begin
            m_mode = 1; m_left = 3 + 1;  // halted after DRAIN_CYC+1 unstalled edges
          end else begin
            m_pc = m_pc + 16'd1;
          end
        end else begin
          m_valid = 1'b0;
          m_left--;
          if (m_left == 0) begin
            m_mode = 2; m_halted = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge CLK) begin
    if (cmp_en && !RST) begin
      chk("m_imem_addr",   32'(IMEM_ADDR),   32'(m_pc));
      chk("m_ifid_valid",  32'(IFID_VALID),  32'(m_valid));
      chk("m_fetch_count", 32'(FETCH_COUNT), 32'(m_count));
      chk("m_halted",      32'(HALTED),      32'(m_halted));
      chk("m_trap",        32'(TRAP),        32'(m_trap));
      if (m_valid) begin
        chk("m_ifid_instr", 32'(IFID_INSTR), 32'(m_instr));
        chk("m_ifid_pc",    32'(IFID_PC),    32'(m_ifpc));
        chk("m_op_code",    32'(OP_CODE),    32'(m_instr[15:12]));
        chk("m_func_code",  32'(FUNC_CODE),  32'(m_instr[3:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {4'h0, i[11:0]};
    mem[0] = 16'h0F0F; mem[1] = 16'h0F0E; mem[2] = 16'h0F0D; mem[7] = 16'hF000;
    RST = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0; WRONG_OP_CODE = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_imem_addr",  32'(IMEM_ADDR), 0);
    chk("rst_ifid_valid", 32'(IFID_VALID), 0);
    chk("rst_ifid_instr", 32'(IFID_INSTR), 0);
    chk("rst_ifid_pc",    32'(IFID_PC), 0);
    chk("rst_count",      32'(FETCH_COUNT), 0);
    chk("rst_halted",     32'(HALTED), 0);
    chk("rst_trap",       32'(TRAP), 0);
    RST = 1'b0; cmp_en = 1'b1;

    // Sequential fetch
    @(negedge CLK); chk("f1_pc", 32'(IFID_PC), 0); chk("f1_func", 32'(FUNC_CODE), 32'hF); chk("f1_op", 32'(OP_CODE), 0);
    @(negedge CLK); chk("f2_pc", 32'(IFID_PC), 1); chk("f2_func", 32'(FUNC_CODE), 32'hE);
    @(negedge CLK); chk("f3_pc", 32'(IFID_PC), 2); chk("f3_func", 32'(FUNC_CODE), 32'hD);
    chk("f3_count", 32'(FETCH_COUNT), 3);
    repeat (2) @(negedge CLK); chk("pre_stall_imem", 32'(IMEM_ADDR), 5);

    // Stall two cycles at PC=5
    STALL = 1'b1; repeat (2) @(negedge CLK);
    chk("stall_imem", 32'(IMEM_ADDR), 5); chk("stall_ifid_pc", 32'(IFID_PC), 4); chk("stall_count", 32'(FETCH_COUNT), 5);
    STALL = 1'b0; @(negedge CLK);
    chk("resume_ifid_pc", 32'(IFID_PC), 5); chk("resume_count", 32'(FETCH_COUNT), 6);

    // Branch together with stall
    BRANCH_TAKEN = 1'b1; STALL = 1'b1; BRANCH_TARGET = 16'h0040; @(negedge CLK);
    chk("br_imem", 32'(IMEM_ADDR), 32'h40); chk("br_bubble", 32'(IFID_VALID), 0);
    BRANCH_TAKEN = 1'b0; STALL = 1'b0; @(negedge CLK);
    chk("br_ifid_pc", 32'(IFID_PC), 32'h40); chk("br_valid", 32'(IFID_VALID), 1);

    // Halt word at 7, full drain
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 16'h0006; @(negedge CLK);
    BRANCH_TAKEN = 1'b0; repeat (2) @(negedge CLK);
    chk("halt_instr", 32'(IFID_INSTR), 32'hF000); chk("halt_imem", 32'(IMEM_ADDR), 7);
    chk("halt_count", 32'(FETCH_COUNT), 9);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK); chk("drain_halted", 32'(HALTED), 0); chk("drain_imem", 32'(IMEM_ADDR), 7);
    end
    @(negedge CLK); chk("halted_after_4", 32'(HALTED), 1);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 16'h0030; WRONG_OP_CODE = 1'b1; STALL = 1'b1;
    repeat (2) @(negedge CLK);
    chk("halt_abs_imem", 32'(IMEM_ADDR), 7); chk("halt_abs_halted", 32'(HALTED), 1); chk("halt_abs_trap", 32'(TRAP), 0);
    BRANCH_TAKEN = 1'b0; WRONG_OP_CODE = 1'b0; STALL = 1'b0;

    // Branch cancels drain
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    repeat (8) @(negedge CLK);
    chk("halt2_imem", 32'(IMEM_ADDR), 7); chk("halt2_count", 32'(FETCH_COUNT), 8);
    @(negedge CLK); STALL = 1'b1; @(negedge CLK); STALL = 1'b0;
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 16'h0010; @(negedge CLK);
    chk("cancel_imem", 32'(IMEM_ADDR), 32'h10); chk("cancel_halted", 32'(HALTED), 0); chk("cancel_valid", 32'(IFID_VALID), 0);
    BRANCH_TAKEN = 1'b0; @(negedge CLK);
    chk("cancel_ifid_pc", 32'(IFID_PC), 32'h10); chk("cancel_count", 32'(FETCH_COUNT), 9);

    // Trap suppressed by branch, ignored with invalid IF/ID, then taken
    WRONG_OP_CODE = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 16'h0020; @(negedge CLK);
    chk("nt_trap", 32'(TRAP), 0); chk("nt_imem", 32'(IMEM_ADDR), 32'h20);
    BRANCH_TAKEN = 1'b0; @(negedge CLK);
    chk("inv_trap", 32'(TRAP), 0); chk("inv_ifid_pc", 32'(IFID_PC), 32'h20);
    @(negedge CLK);
    chk("trap_set", 32'(TRAP), 1); chk("trap_valid", 32'(IFID_VALID), 0); chk("trap_imem", 32'(IMEM_ADDR), 32'h21);
    STALL = 1'b1; @(negedge CLK); STALL = 1'b0; WRONG_OP_CODE = 1'b0; @(negedge CLK);
    chk("trap_frozen", 32'(IMEM_ADDR), 32'h21); chk("trap_sticky", 32'(TRAP), 1);
    #2 RST = 1'b1;
    #1 chk("async_trap", 32'(TRAP), 0); chk("async_imem", 32'(IMEM_ADDR), 0);
    chk("async_valid", 32'(IFID_VALID), 0); chk("async_count", 32'(FETCH_COUNT), 0);
    @(negedge CLK); mem[7] = 16'h0007; RST = 1'b0;

    // PC and FETCH_COUNT wrap
    repeat (65535) @(negedge CLK);
    chk("pre_wrap_imem", 32'(IMEM_ADDR), 32'hFFFF); chk("pre_wrap_count", 32'(FETCH_COUNT), 32'hFFFF);
    @(negedge CLK);
    chk("wrap_imem", 32'(IMEM_ADDR), 0); chk("wrap_count", 32'(FETCH_COUNT), 0);
    chk("wrap_ifid_pc", 32'(IFID_PC), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
